// File: rtl/bz_worm_arbiter.sv
// bz_worm_arbiter: worm-granular round-robin arbiter that shares one router
// input FIFO write port among NUM_REQ BZ serializers. A granted requester owns
// the FIFO until it delivers a flit with tail=1, so worms never interleave.
// Also raises a sticky flag when a worm runs longer than MAX_WORM_LEN flits.
module bz_worm_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FLIT_W       = 11,
  parameter int MAX_WORM_LEN = 64
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_REQ*FLIT_W-1:0]                      req_flit,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic                                           is_full,
  output logic [FLIT_W-1:0]                              data_out,
  output logic                                           wrreq,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                           busy,
  output logic                                           worm_overrun
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_WORM_LEN + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_flit_cnt;
  logic [FLIT_W-1:0]   r_data_out;
  logic                r_wrreq;
  logic                r_overrun;

  logic [FLIT_W-1:0]   w_flit [NUM_REQ];
  logic [FLIT_W-1:0]   w_sel_flit;
  logic                w_sel_valid;
  logic                w_xfer;
  logic                w_tail_xfer;
  logic                w_found;
  logic [GW-1:0]       w_winner;
  logic [GW-1:0]       w_rr_after;

  // Unpack the flat flit bus into one flit per requester
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_flit[gi] = req_flit[gi*FLIT_W +: FLIT_W];
    end
  endgenerate

  assign w_sel_flit  = w_flit[r_grant];
  assign w_sel_valid = req_valid[r_grant];
  // A flit moves only in LOCKED, from the owner, when the FIFO has room
  assign w_xfer      = (r_state == ST_LOCKED) && w_sel_valid && !is_full;
  assign w_tail_xfer = w_xfer && w_sel_flit[0];
  assign w_rr_after  = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);

  // Round-robin pick: first valid requester scanning upward from rr_ptr
  always_comb begin
    int unsigned v_idx;
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    v_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_winner = GW'(v_idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: lock on any request, unlock only after the tail flit moves
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_found) w_state_next = ST_LOCKED;
      ST_LOCKED: if (w_tail_xfer) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Outputs from state: ready depends on state and is_full only, never on valid
  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    if (r_state == ST_LOCKED) begin
      busy               = 1'b1;
      req_ready[r_grant] = !is_full;
    end
  end

  // Grant, round-robin pointer and per-worm flit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_flit_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_found) begin
        r_grant    <= w_winner;
        r_flit_cnt <= '0;
      end
      if (w_xfer && (r_flit_cnt != CW'(MAX_WORM_LEN))) begin
        r_flit_cnt <= r_flit_cnt + CW'(1);
      end
      if (w_tail_xfer) begin
        r_rr_ptr <= w_rr_after;
      end
    end
  end

  // Registered FIFO write; data_out keeps the last written flit when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
      r_wrreq    <= 1'b0;
    end else begin
      r_wrreq <= w_xfer;
      if (w_xfer) begin
        r_data_out <= w_sel_flit;
      end
    end
  end

  // Sticky runaway flag: a non-tail flit accepted as the MAX_WORM_LEN-th flit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_xfer && !w_sel_flit[0] && (r_flit_cnt == CW'(MAX_WORM_LEN - 1))) begin
      r_overrun <= 1'b1;
    end
  end

  assign data_out     = r_data_out;
  assign wrreq        = r_wrreq;
  assign grant_id     = r_grant;
  assign worm_overrun = r_overrun;

endmodule

// File: tb/tb_bz_worm_arbiter.sv
// Directed bench for bz_worm_arbiter: per-requester flit queues feed the DUT,
// every cycle's wrreq/data_out/busy/grant_id is compared against hand traces.
module tb_bz_worm_arbiter;

  localparam int NR = 4;
  localparam int FW = 11;
  localparam int MW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR*FW-1:0]  req_flit;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic              is_full;
  logic [FW-1:0]     data_out;
  logic              wrreq;
  logic [1:0]        grant_id;
  logic              busy;
  logic              worm_overrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [FW-1:0] fq [NR][8];
  int            fq_head [NR];
  int            fq_cnt [NR];
  logic [NR-1:0] en;

  always #5 clk = ~clk;

  bz_worm_arbiter #(
    .NUM_REQ      (NR),
    .FLIT_W       (FW),
    .MAX_WORM_LEN (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_flit     (req_flit),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .is_full      (is_full),
    .data_out     (data_out),
    .wrreq        (wrreq),
    .grant_id     (grant_id),
    .busy         (busy),
    .worm_overrun (worm_overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (fq_cnt[i] != 0);
      req_flit[i*FW +: FW] = (fq_cnt[i] != 0) ? fq[i][fq_head[i]] : '0;
    end
  endtask

  task automatic push(input int r, input logic [FW-1:0] v);
    fq[r][(fq_head[r] + fq_cnt[r]) % 8] = v;
    fq_cnt[r]++;
    drive();
  endtask

  // One clock: note what is accepted at the edge, then pop those flits
  task automatic tick();
    logic [NR-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        fq_head[i] = (fq_head[i] + 1) % 8;
        fq_cnt[i]--;
      end
    end
    drive();
  endtask

  task automatic cyc(input string tag, input logic wr_e, input logic [FW-1:0] d_e,
                     input logic busy_e, input logic [1:0] g_e);
    tick();
    check_eq({tag, ".wrreq"}, 32'(wrreq), 32'(wr_e));
    check_eq({tag, ".data"}, 32'(data_out), 32'(d_e));
    check_eq({tag, ".busy"}, 32'(busy), 32'(busy_e));
    check_eq({tag, ".grant"}, 32'(grant_id), 32'(g_e));
    $display("%-10s wrreq=%0d data=0x%03h busy=%0d grant=%0d ready=%b ovr=%0d",
             tag, wrreq, data_out, busy, grant_id, req_ready, worm_overrun);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".data"}, 32'(data_out), 32'h0);
    check_eq({tag, ".wrreq"}, 32'(wrreq), 32'h0);
    check_eq({tag, ".busy"}, 32'(busy), 32'h0);
    check_eq({tag, ".grant"}, 32'(grant_id), 32'h0);
    check_eq({tag, ".ovr"}, 32'(worm_overrun), 32'h0);
    check_eq({tag, ".ready"}, 32'(req_ready), 32'h0);
  endtask

  initial begin
    is_full = 1'b0;
    en      = '1;
    for (int i = 0; i < NR; i++) begin
      fq_head[i] = 0;
      fq_cnt[i]  = 0;
      for (int j = 0; j < 8; j++) fq[i][j] = '0;
    end
    drive();

    // Power-on reset
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Four requesters, two-flit worms, req0 queues a second worm
    for (int i = 0; i < NR; i++) begin
      push(i, 11'(12'h100 + 12'(i * 16)));
      push(i, 11'(12'h201 + 12'(i * 16)));
    end
    push(0, 11'h140);
    push(0, 11'h241);
    cyc("rr.t1",  1'b0, 11'h000, 1'b1, 2'd0);
    cyc("rr.t2",  1'b1, 11'h100, 1'b1, 2'd0);
    cyc("rr.t3",  1'b1, 11'h201, 1'b0, 2'd0);
    cyc("rr.t4",  1'b0, 11'h201, 1'b1, 2'd1);
    cyc("rr.t5",  1'b1, 11'h110, 1'b1, 2'd1);
    cyc("rr.t6",  1'b1, 11'h211, 1'b0, 2'd1);
    cyc("rr.t7",  1'b0, 11'h211, 1'b1, 2'd2);
    cyc("rr.t8",  1'b1, 11'h120, 1'b1, 2'd2);
    cyc("rr.t9",  1'b1, 11'h221, 1'b0, 2'd2);
    cyc("rr.t10", 1'b0, 11'h221, 1'b1, 2'd3);
    cyc("rr.t11", 1'b1, 11'h130, 1'b1, 2'd3);
    cyc("rr.t12", 1'b1, 11'h231, 1'b0, 2'd3);
    cyc("rr.t13", 1'b0, 11'h231, 1'b1, 2'd0);
    cyc("rr.t14", 1'b1, 11'h140, 1'b1, 2'd0);
    cyc("rr.t15", 1'b1, 11'h241, 1'b0, 2'd0);
    cyc("rr.t16", 1'b0, 11'h241, 1'b0, 2'd0);

    // Req0 alone, three-flit worm
    push(0, 11'h2AA);
    push(0, 11'h3FE);
    push(0, 11'h155);
    cyc("w3.t1", 1'b0, 11'h241, 1'b1, 2'd0);
    cyc("w3.t2", 1'b1, 11'h2AA, 1'b1, 2'd0);
    cyc("w3.t3", 1'b1, 11'h3FE, 1'b1, 2'd0);
    cyc("w3.t4", 1'b1, 11'h155, 1'b0, 2'd0);
    cyc("w3.t5", 1'b0, 11'h155, 1'b0, 2'd0);

    // rr_ptr is now 1: req1 beats req0; single-flit worms
    push(0, 11'h051);
    push(1, 11'h061);
    cyc("ptr.t1", 1'b0, 11'h155, 1'b1, 2'd1);
    cyc("ptr.t2", 1'b1, 11'h061, 1'b0, 2'd1);
    cyc("ptr.t3", 1'b0, 11'h061, 1'b1, 2'd0);
    cyc("ptr.t4", 1'b1, 11'h051, 1'b0, 2'd0);

    // Owner drops valid mid-worm for 5 cycles while req1 waits
    push(0, 11'h300);
    push(0, 11'h302);
    push(0, 11'h305);
    cyc("hold.t1", 1'b0, 11'h051, 1'b1, 2'd0);
    cyc("hold.t2", 1'b1, 11'h300, 1'b1, 2'd0);
    en[0] = 1'b0;
    push(1, 11'h071);
    for (int c = 0; c < 5; c++) begin
      cyc($sformatf("hold.d%0d", c), 1'b0, 11'h300, 1'b1, 2'd0);
      check_eq($sformatf("hold.d%0d.ready", c), 32'(req_ready), 32'h1);
    end
    en[0] = 1'b1;
    drive();
    cyc("hold.t3", 1'b1, 11'h302, 1'b1, 2'd0);
    cyc("hold.t4", 1'b1, 11'h305, 1'b0, 2'd0);
    cyc("hold.t5", 1'b0, 11'h305, 1'b1, 2'd1);
    cyc("hold.t6", 1'b1, 11'h071, 1'b0, 2'd1);

    // FIFO almost-full for 3 cycles mid-worm
    for (int i = 0; i < 4; i++) push(3, 11'(12'h400 + 12'(i * 16) + ((i == 3) ? 12'h1 : 12'h0)));
    cyc("full.t1", 1'b0, 11'h071, 1'b1, 2'd3);
    cyc("full.t2", 1'b1, 11'h400, 1'b1, 2'd3);
    is_full = 1'b1;
    #1;
    check_eq("full.rise.ready", 32'(req_ready), 32'h0);
    check_eq("full.rise.wrreq", 32'(wrreq), 32'h1);
    for (int c = 0; c < 3; c++) begin
      cyc($sformatf("full.s%0d", c), 1'b0, 11'h400, 1'b1, 2'd3);
      check_eq($sformatf("full.s%0d.ready", c), 32'(req_ready), 32'h0);
    end
    is_full = 1'b0;
    #1;
    check_eq("full.fall.ready", 32'(req_ready), 32'h8);
    cyc("full.t3", 1'b1, 11'h410, 1'b1, 2'd3);
    cyc("full.t4", 1'b1, 11'h420, 1'b1, 2'd3);
    cyc("full.t5", 1'b1, 11'h431, 1'b0, 2'd3);
    cyc("full.t6", 1'b0, 11'h431, 1'b0, 2'd3);

    // Runaway worm: req2 sends 5 non-tail flits with MAX_WORM_LEN=4
    for (int i = 0; i < 5; i++) push(2, 11'(12'h500 + 12'(i * 16)));
    cyc("ovr.t1", 1'b0, 11'h431, 1'b1, 2'd2);
    check_eq("ovr.t1.flag", 32'(worm_overrun), 32'h0);
    cyc("ovr.t2", 1'b1, 11'h500, 1'b1, 2'd2);
    cyc("ovr.t3", 1'b1, 11'h510, 1'b1, 2'd2);
    cyc("ovr.t4", 1'b1, 11'h520, 1'b1, 2'd2);
    check_eq("ovr.t4.flag", 32'(worm_overrun), 32'h0);
    cyc("ovr.t5", 1'b1, 11'h530, 1'b1, 2'd2);
    check_eq("ovr.t5.flag", 32'(worm_overrun), 32'h1);
    cyc("ovr.t6", 1'b1, 11'h540, 1'b1, 2'd2);
    check_eq("ovr.t6.flag", 32'(worm_overrun), 32'h1);
    push(2, 11'h551);
    cyc("ovr.t7", 1'b1, 11'h551, 1'b0, 2'd2);
    cyc("ovr.t8", 1'b0, 11'h551, 1'b0, 2'd2);
    check_eq("ovr.t8.flag", 32'(worm_overrun), 32'h1);

    // Reset pulse in the middle of a worm (rr_ptr is 3 here)
    push(1, 11'h600);
    push(1, 11'h610);
    push(1, 11'h621);
    cyc("rst.t1", 1'b0, 11'h551, 1'b1, 2'd1);
    cyc("rst.t2", 1'b1, 11'h600, 1'b1, 2'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst.async");
    tick();
    check_reset_outputs("rst.held");
    reset = 1'b1;
    fq_cnt[1] = 0;
    drive();
    for (int i = 0; i < NR; i++) push(i, 11'(12'h701 + 12'(i * 16)));
    cyc("rst.t3", 1'b0, 11'h000, 1'b1, 2'd0);
    cyc("rst.t4", 1'b1, 11'h701, 1'b0, 2'd0);
    cyc("rst.t5", 1'b0, 11'h701, 1'b1, 2'd1);
    cyc("rst.t6", 1'b1, 11'h711, 1'b0, 2'd1);
    check_eq("rst.t6.flag", 32'(worm_overrun), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
